// File: rtl/sobel_3x3.sv
// rtl/sobel_3x3.sv - 3x3 Sobel gradient magnitude, 3-stage pipeline with border suppression
// Optional binary threshold output when SOBEL_THRESHOLD_EN is defined.
module sobel_3x3 #(
  parameter int DSIZE        = 8,
  parameter int VIDEO_WIDTH  = 1920,
  parameter int VIDEO_HEIGHT = 1080
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             invs,
  input  logic             inde,
`ifdef SOBEL_THRESHOLD_EN
  input  logic [DSIZE-1:0] thresh,
`endif
  input  logic [DSIZE-1:0] win00,
  input  logic [DSIZE-1:0] win01,
  input  logic [DSIZE-1:0] win02,
  input  logic [DSIZE-1:0] win10,
  input  logic [DSIZE-1:0] win11,
  input  logic [DSIZE-1:0] win12,
  input  logic [DSIZE-1:0] win20,
  input  logic [DSIZE-1:0] win21,
  input  logic [DSIZE-1:0] win22,
  output logic             outvs,
  output logic             outde,
  output logic [DSIZE-1:0] outdata
);

  localparam int SW = DSIZE + 3;
  localparam int CW = (VIDEO_WIDTH  > 1) ? $clog2(VIDEO_WIDTH)  : 1;
  localparam int RW = (VIDEO_HEIGHT > 1) ? $clog2(VIDEO_HEIGHT) : 1;
  localparam logic [CW-1:0]    COL_LAST = CW'(VIDEO_WIDTH - 1);
  localparam logic [RW-1:0]    ROW_LAST = RW'(VIDEO_HEIGHT - 1);
  localparam logic [DSIZE-1:0] PIX_MAX  = '1;

  // The centre tap carries no weight in either kernel.
  logic unused_center;
  assign unused_center = ^win11;

  logic          invs_d, inde_d;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          vs_edge, de_fall, border;

  assign vs_edge = invs ^ invs_d;
  assign de_fall = inde_d & ~inde;
  assign border  = (col == '0) || (col == COL_LAST) || (row == '0) || (row == ROW_LAST);

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      invs_d <= 1'b0;
      inde_d <= 1'b0;
      col    <= '0;
      row    <= '0;
    end else begin
      invs_d <= invs;
      inde_d <= inde;
      if (!inde)
        col <= '0;
      else if (col != COL_LAST)
        col <= col + 1'b1;
      // Frame boundary takes priority over the end-of-line advance.
      if (vs_edge)
        row <= '0;
      else if (de_fall && (row != ROW_LAST))
        row <= row + 1'b1;
    end
  end

  logic [SW-1:0] gx_pos, gx_neg, gy_pos, gy_neg;
  assign gx_pos = SW'(win02) + (SW'(win12) << 1) + SW'(win22);
  assign gx_neg = SW'(win00) + (SW'(win10) << 1) + SW'(win20);
  assign gy_pos = SW'(win20) + (SW'(win21) << 1) + SW'(win22);
  assign gy_neg = SW'(win00) + (SW'(win01) << 1) + SW'(win02);

  logic signed [SW-1:0] gx1, gy1;
  logic                 vs1, de1, bd1;
  logic [SW-1:0]        ax2, ay2;
  logic                 vs2, de2, bd2;

  logic [SW-1:0]    mag;
  logic [DSIZE-1:0] sat, res;

  always_comb begin
    mag = ax2 + ay2;
    sat = (mag > SW'(PIX_MAX)) ? PIX_MAX : mag[DSIZE-1:0];
`ifdef SOBEL_THRESHOLD_EN
    res = (sat >= thresh) ? PIX_MAX : '0;
`else
    res = sat;
`endif
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      gx1     <= '0;
      gy1     <= '0;
      vs1     <= 1'b0;
      de1     <= 1'b0;
      bd1     <= 1'b0;
      ax2     <= '0;
      ay2     <= '0;
      vs2     <= 1'b0;
      de2     <= 1'b0;
      bd2     <= 1'b0;
      outvs   <= 1'b0;
      outde   <= 1'b0;
      outdata <= '0;
    end else begin
      gx1     <= signed'(gx_pos - gx_neg);
      gy1     <= signed'(gy_pos - gy_neg);
      vs1     <= invs;
      de1     <= inde;
      bd1     <= border;
      ax2     <= gx1[SW-1] ? $unsigned(-gx1) : $unsigned(gx1);
      ay2     <= gy1[SW-1] ? $unsigned(-gy1) : $unsigned(gy1);
      vs2     <= vs1;
      de2     <= de1;
      bd2     <= bd1;
      outvs   <= vs2;
      outde   <= de2;
      outdata <= (de2 && !bd2) ? res : '0;
    end
  end

endmodule

// File: tb/tb_sobel_3x3.sv
// tb/tb_sobel_3x3.sv - directed self-checking bench for sobel_3x3 (default 1920x1080, DSIZE=8)
module tb_sobel_3x3;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       invs  = 1'b0;
  logic       inde  = 1'b0;
  logic [7:0] w [9];
  logic       outvs, outde;
  logic [7:0] outdata;
`ifdef SOBEL_THRESHOLD_EN
  logic [7:0] thresh = 8'd100;
`endif

  int   checks   = 0;
  int   failures = 0;
  logic vs_lvl   = 1'b0;

  typedef struct {
    logic       vs;
    logic       de;
    logic [7:0] data;
    string      tag;
  } exp_t;
  exp_t q[$];

  always #5 clock = ~clock;

  sobel_3x3 dut (
    .clock  (clock),
    .rst_n  (rst_n),
    .invs   (invs),
    .inde   (inde),
`ifdef SOBEL_THRESHOLD_EN
    .thresh (thresh),
`endif
    .win00  (w[0]), .win01(w[1]), .win02(w[2]),
    .win10  (w[3]), .win11(w[4]), .win12(w[5]),
    .win20  (w[6]), .win21(w[7]), .win22(w[8]),
    .outvs  (outvs),
    .outde  (outde),
    .outdata(outdata)
  );

  function automatic logic [7:0] mag_out(input int m);
    logic [7:0] s;
    s = (m > 255) ? 8'd255 : m[7:0];
`ifdef SOBEL_THRESHOLD_EN
    return (s >= thresh) ? 8'd255 : 8'd0;
`else
    return s;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_win(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7, a8);
    w[0] = a0; w[1] = a1; w[2] = a2;
    w[3] = a3; w[4] = a4; w[5] = a5;
    w[6] = a6; w[7] = a7; w[8] = a8;
  endtask

  task automatic win_flat();      set_win(8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40); endtask
  task automatic win_grad();      set_win(8'd10, 8'd0, 8'd20, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);       endtask
  task automatic win_edge();      set_win(8'd0, 8'd100, 8'd100, 8'd0, 8'd100, 8'd100, 8'd0, 8'd100, 8'd100); endtask
  task automatic win_g12(input logic [7:0] v); set_win(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, v, 8'd0, 8'd0, 8'd0); endtask

  // Drive one window; the entry pushed now is checked three cycles later.
  task automatic step(input logic de, input logic [7:0] edata, input string tag);
    exp_t e;
    invs   = vs_lvl;
    inde   = de;
    e.vs   = vs_lvl;
    e.de   = de;
    e.data = de ? edata : 8'd0;
    e.tag  = tag;
    q.push_back(e);
    @(negedge clock);
    if (q.size() == 3) begin
      e = q.pop_front();
      check({e.tag, "_vs"},   32'(outvs),   32'(e.vs));
      check({e.tag, "_de"},   32'(outde),   32'(e.de));
      check({e.tag, "_data"}, 32'(outdata), 32'(e.data));
    end
  endtask

  task automatic reset_pulse(input int n);
    exp_t z;
    rst_n = 1'b0;
    invs  = vs_lvl;
    repeat (n) begin
      @(negedge clock);
      check("rst_vs",   32'(outvs),   32'd0);
      check("rst_de",   32'(outde),   32'd0);
      check("rst_data", 32'(outdata), 32'd0);
    end
    q.delete();
    z.vs = 1'b0; z.de = 1'b0; z.data = 8'd0; z.tag = "post_rst";
    q.push_back(z);
    q.push_back(z);
    rst_n = 1'b1;
  endtask

  initial begin
    win_flat();
    reset_pulse(3);

    win_edge(); step(0, 8'd0, "idle"); step(0, 8'd0, "idle");

    win_grad();
    step(1, 8'd0, "r0c0"); step(1, 8'd0, "r0c1"); step(1, 8'd0, "r0c2");
    win_edge(); step(0, 8'd0, "gap0");

    win_grad();   step(1, 8'd0,          "r1c0_grad");
    win_grad();   step(1, mag_out(40),   "r1c1_grad");
    win_flat();   step(1, mag_out(0),    "r1_flat");
    win_edge();   step(1, mag_out(400),  "r1_vedge");
    win_g12(127); step(1, mag_out(254),  "r1_m254");
    win_g12(128); step(1, mag_out(256),  "r1_m256");
    win_g12(49);  step(1, mag_out(98),   "r1_m98");
    win_g12(50);  step(1, mag_out(100),  "r1_m100");
    win_g12(150); step(1, mag_out(300),  "r1_m300");
    set_win(8'd0, 8'd0, 8'd0, 8'd128, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    step(1, mag_out(256), "r1_neg_gx");
    win_edge(); step(0, 8'd0, "gap1");

    for (int r = 2; r < 50; r++) begin
      win_flat(); step(1, mag_out(0), "short");
      step(0, 8'd0, "gap");
    end

    for (int c = 0; c <= 1920; c++) begin
      string t;
      t = $sformatf("r50c%0d", c);
      if (c == 100) begin
        win_edge(); step(1, mag_out(400), t);
      end else if (c == 0) begin
        win_grad(); step(1, 8'd0, t);
      end else if (c == 1918) begin
        win_grad(); step(1, mag_out(40), t);
      end else if (c >= 1919) begin
        win_grad(); step(1, 8'd0, t);
      end else begin
        win_flat(); step(1, mag_out(0), t);
      end
    end
    step(0, 8'd0, "gap50");

    win_grad();
    step(1, 8'd0, "r51c0");
    for (int c = 1; c < 5; c++) step(1, mag_out(40), "r51_mid");
    inde = 1'b1;
    reset_pulse(1);
    for (int c = 0; c < 4; c++) step(1, 8'd0, "rst_row0");
    step(0, 8'd0, "rst_gap");
    step(1, 8'd0, "rst_row1_c0");
    step(1, mag_out(40), "rst_row1_c1");
    step(0, 8'd0, "rst_gap2");

    vs_lvl = ~vs_lvl;
    step(0, 8'd0, "vs_edge");
    for (int r = 0; r < 1078; r++) begin
      win_flat(); step(1, mag_out(0), "frame_line");
      step(0, 8'd0, "frame_gap");
    end
    win_grad();
    step(1, 8'd0, "r1078c0"); step(1, mag_out(40), "r1078c1"); step(0, 8'd0, "gap1078");
    step(1, 8'd0, "r1079c0"); step(1, 8'd0, "r1079c1");         step(0, 8'd0, "gap1079");
    step(1, 8'd0, "rhold_c0"); step(1, 8'd0, "rhold_c1");
    vs_lvl = ~vs_lvl;
    step(0, 8'd0, "vs_and_fall");
    step(1, 8'd0, "nf_r0c0"); step(1, 8'd0, "nf_r0c1"); step(1, 8'd0, "nf_r0c2");
    step(0, 8'd0, "nf_gap");
    step(1, 8'd0, "nf_r1c0"); step(1, mag_out(40), "nf_r1c1");
    repeat (3) step(0, 8'd0, "drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
